// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the per-register write-pending scoreboard.
// ScbCntW  : default width of each pending counter
// NReg     : number of architectural registers
// ScbAddrW : register address width (fixed at 5)
// cnt_max  : largest value a counter of the given width can hold
package reg_scoreboard_pkg;

  localparam int unsigned ScbCntW  = 2;
  localparam int unsigned NReg     = 32;
  localparam int unsigned ScbAddrW = 5;

  function automatic int unsigned cnt_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/reg_scoreboard_cnt_slot.sv
// One saturating up/down pending-write counter for a single register.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   inc, dec, clr        : allocate, release, flush (clr wins; inc+dec cancel)
//   cnt                  : current count
//   full, zero           : count at maximum / count at zero
//   ovf_pulse, unf_pulse : inc refused at max / dec refused at zero (this cycle)
module reg_scoreboard_cnt_slot
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = ScbCntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             zero,
  output logic             ovf_pulse,
  output logic             unf_pulse
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt  = cnt_q;
  assign full = (cnt_q == CntMax);
  assign zero = (cnt_q == '0);

  always_comb begin
    cnt_d     = cnt_q;
    ovf_pulse = 1'b0;
    unf_pulse = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && dec) begin
      // Simultaneous alloc and release net to zero, even at the limits.
      cnt_d = cnt_q;
    end else if (inc) begin
      if (full) ovf_pulse = 1'b1;
      else      cnt_d     = cnt_q + 1'b1;
    end else if (dec) begin
      if (zero) unf_pulse = 1'b1;
      else      cnt_d     = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-GPR write-pending scoreboard gating instruction issue out of decode.
// Optional feature: define SCB_PERF_EN to add the stall_cycles counter port.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   query_valid, rs/rt/dst_addr,
//   dst_we                         : decode-stage instruction being checked
//   alloc_valid/addr               : destination allocated as instruction leaves ID
//   release_valid/addr             : register write retired at writeback
//   flush                          : discard all pending counts
//   rs_busy, rt_busy, dst_full     : hazard status for the decode addresses
//   issue_stall                    : decode must hold this cycle
//   err_overflow, err_underflow    : sticky misuse flags, cleared only by reset
//   stall_cycles (SCB_PERF_EN)     : saturating count of stalled cycles
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = ScbCntW,
  parameter int unsigned NREG  = NReg
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                query_valid,
  input  logic [ScbAddrW-1:0] rs_addr,
  input  logic [ScbAddrW-1:0] rt_addr,
  input  logic [ScbAddrW-1:0] dst_addr,
  input  logic                dst_we,
  input  logic                alloc_valid,
  input  logic [ScbAddrW-1:0] alloc_addr,
  input  logic                release_valid,
  input  logic [ScbAddrW-1:0] release_addr,
  input  logic                flush,
  output logic                rs_busy,
  output logic                rt_busy,
  output logic                dst_full,
  output logic                issue_stall,
  output logic                err_overflow,
`ifdef SCB_PERF_EN
  output logic                err_underflow,
  output logic [31:0]         stall_cycles
`else
  output logic                err_underflow
`endif
);

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  full;
  logic [NREG-1:0]  zero;
  logic [NREG-1:0]  ovf_pulse;
  logic [NREG-1:0]  unf_pulse;

  // r0 has no counter: it always reads as idle and never flags errors.
  assign cnt[0]       = '0;
  assign full[0]      = 1'b0;
  assign zero[0]      = 1'b1;
  assign ovf_pulse[0] = 1'b0;
  assign unf_pulse[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_slot
    logic inc, dec;
    assign inc = alloc_valid   && (alloc_addr   == ScbAddrW'(i));
    assign dec = release_valid && (release_addr == ScbAddrW'(i));

    reg_scoreboard_cnt_slot #(
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc),
      .dec       (dec),
      .clr       (flush),
      .cnt       (cnt[i]),
      .full      (full[i]),
      .zero      (zero[i]),
      .ovf_pulse (ovf_pulse[i]),
      .unf_pulse (unf_pulse[i])
    );
  end

  // Status comes only from registered counts: no bypass of this cycle's alloc/release.
  // cnt and zero are equivalent views of the same state.
  always_comb begin
    rs_busy     = (cnt[rs_addr] != '0);
    rt_busy     = !zero[rt_addr];
    dst_full    = dst_we && full[dst_addr];
    issue_stall = query_valid && (rs_busy || rt_busy || dst_full);
  end

  logic err_overflow_q, err_overflow_d;
  logic err_underflow_q, err_underflow_d;

  always_comb begin
    err_overflow_d  = err_overflow_q  | (|ovf_pulse);
    err_underflow_d = err_underflow_q | (|unf_pulse);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

`ifdef SCB_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (issue_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // Survives flush so it measures stalls across pipeline cancels.
  always_ff @(posedge clk) begin
    if (reset) stall_cycles_q <= '0;
    else       stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomised bench for reg_scoreboard against an integer-array reference model.
// Build with SCB_PERF_EN defined to also check stall_cycles.
module tb_reg_scoreboard;

  localparam int Max = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       query_valid;
  logic [4:0] rs_addr, rt_addr, dst_addr;
  logic       dst_we;
  logic       alloc_valid;
  logic [4:0] alloc_addr;
  logic       release_valid;
  logic [4:0] release_addr;
  logic       flush;
  logic       rs_busy, rt_busy, dst_full, issue_stall;
  logic       err_overflow, err_underflow;
`ifdef SCB_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .query_valid   (query_valid),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .dst_addr      (dst_addr),
    .dst_we        (dst_we),
    .alloc_valid   (alloc_valid),
    .alloc_addr    (alloc_addr),
    .release_valid (release_valid),
    .release_addr  (release_addr),
    .flush         (flush),
    .rs_busy       (rs_busy),
    .rt_busy       (rt_busy),
    .dst_full      (dst_full),
    .issue_stall   (issue_stall),
    .err_overflow  (err_overflow),
`ifdef SCB_PERF_EN
    .err_underflow (err_underflow),
    .stall_cycles  (stall_cycles)
`else
    .err_underflow (err_underflow)
`endif
  );

  // Reference model: pending writes per register, sticky flags, stall count.
  int          m_cnt [32];
  bit          m_ovf, m_unf;
  longint      m_stall;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_busy(input logic [4:0] a);
    return (a != 0) && (m_cnt[a] != 0);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_ovf   = 0;
    m_unf   = 0;
    m_stall = 0;
  endtask

  // Drive one cycle's inputs, check outputs against the model, then advance the model
  // at the clock edge. Called just after a negedge.
  task automatic step(input bit q, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] dst, input bit we, input bit av,
                      input logic [4:0] aa, input bit rv, input logic [4:0] ra,
                      input bit fl, input bit rst);
    bit e_rs, e_rt, e_full, e_stall;
    query_valid   = q;
    rs_addr       = rs;
    rt_addr       = rt;
    dst_addr      = dst;
    dst_we        = we;
    alloc_valid   = av;
    alloc_addr    = aa;
    release_valid = rv;
    release_addr  = ra;
    flush         = fl;
    reset         = rst;
    #1;
    e_rs    = m_busy(rs);
    e_rt    = m_busy(rt);
    e_full  = we && (dst != 0) && (m_cnt[dst] == Max);
    e_stall = q && (e_rs || e_rt || e_full);
    check_val("rs_busy", 32'(rs_busy), 32'(e_rs));
    check_val("rt_busy", 32'(rt_busy), 32'(e_rt));
    check_val("dst_full", 32'(dst_full), 32'(e_full));
    check_val("issue_stall", 32'(issue_stall), 32'(e_stall));
    check_val("err_overflow", 32'(err_overflow), 32'(m_ovf));
    check_val("err_underflow", 32'(err_underflow), 32'(m_unf));
`ifdef SCB_PERF_EN
    check_val("stall_cycles", stall_cycles, 32'(m_stall));
`endif
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (e_stall && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (fl) begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      end else begin
        bit same = av && rv && (aa == ra);
        if (av && aa != 0 && !same) begin
          if (m_cnt[aa] == Max) m_ovf = 1;
          else m_cnt[aa]++;
        end
        if (rv && ra != 0 && !same) begin
          if (m_cnt[ra] == 0) m_unf = 1;
          else m_cnt[ra]--;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit q, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] dst, input bit we);
    step(q, rs, rt, dst, we, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    query_valid = 0; rs_addr = 0; rt_addr = 0; dst_addr = 0; dst_we = 0;
    alloc_valid = 0; alloc_addr = 0; release_valid = 0; release_addr = 0;
    flush = 0; reset = 1;
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Alloc r5, observe busy one cycle later, release, observe clear one cycle later.
    step(1, 5, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    idle(1, 5, 0, 0, 0);
    check_val("r5_busy_after_alloc", 32'(rs_busy), 32'd1);
    step(1, 5, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    idle(1, 5, 0, 0, 0);
    check_val("r5_idle_after_release", 32'(rs_busy), 32'd0);

    // Saturate r7, overflow, drain.
    repeat (3) step(1, 0, 7, 7, 1, 1, 7, 0, 0, 0, 0);
    idle(1, 0, 7, 7, 1);
    check_val("r7_full", 32'(dst_full), 32'd1);
    step(1, 0, 7, 7, 1, 1, 7, 0, 0, 0, 0);
    idle(1, 0, 7, 7, 1);
    check_val("ovf_sticky", 32'(err_overflow), 32'd1);
    repeat (3) step(1, 0, 7, 7, 1, 0, 0, 1, 7, 0, 0);
    idle(1, 0, 7, 7, 1);
    check_val("r7_drained", 32'(rt_busy), 32'd0);

    // Same-address alloc/release cancel; independent addresses update together.
    step(0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
    step(1, 9, 0, 0, 0, 1, 9, 1, 9, 0, 0);
    step(1, 9, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    step(1, 3, 4, 0, 0, 1, 3, 1, 4, 0, 0);
    idle(1, 3, 4, 9, 1);

    // r0 is never tracked.
    step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);

    // Underflow survives flush; flush beats a same-cycle alloc.
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    step(1, 2, 3, 4, 1, 1, 2, 0, 0, 0, 0);
    step(1, 2, 3, 4, 1, 1, 3, 0, 0, 0, 0);
    step(1, 2, 3, 4, 1, 1, 4, 0, 0, 0, 0);
    step(1, 2, 3, 5, 1, 1, 5, 0, 0, 1, 0);
    idle(1, 2, 5, 4, 1);
    check_val("unf_after_flush", 32'(err_underflow), 32'd1);
    idle(1, 3, 4, 5, 1);

    // Reset with in-flight traffic clears everything.
    step(1, 3, 0, 0, 0, 1, 3, 1, 9, 0, 1);
    idle(1, 3, 9, 3, 1);

    // Randomised traffic over a small address window to force collisions and saturation.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] a [5];
      for (int k = 0; k < 5; k++) begin
        a[k] = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
      end
      step($urandom_range(0, 3) != 0, a[0], a[1], a[2], $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, a[3], $urandom_range(0, 2) == 0, a[4],
           $urandom_range(0, 29) == 0, $urandom_range(0, 249) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
